// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and data access.
// Define ARB_ROUND_ROBIN_EN to replace data priority plus the starvation guard with round-robin.
module mem_port_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    output logic          if_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          d_stall,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic          ram_wren,
    input  logic [DW-1:0] ram_q,
    output logic          busy,
    output logic          owner
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]    state;
    logic [2:0]    wait_cnt;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic          lat_we;
    logic          grant_if;

`ifdef ARB_ROUND_ROBIN_EN
    // owner still reflects the previous grant while in IDLE, so a tie goes to the other side
    always_comb grant_if = if_req && (!d_req || owner);
`else
    logic [3:0] starve_cnt;

    always_comb grant_if = if_req && (!d_req || (starve_cnt >= 4'(MAX_WAIT)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (state == IDLE && if_req) begin
            if (grant_if)
                starve_cnt <= '0;
            else if (starve_cnt != 4'hF)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            owner     <= 1'b0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        state <= ACCESS;
                        if (grant_if) begin
                            owner    <= 1'b0;
                            lat_addr <= if_addr;
                            lat_we   <= 1'b0;
                        end else begin
                            owner     <= 1'b1;
                            lat_addr  <= d_addr;
                            lat_we    <= d_we;
                            lat_wdata <= d_wdata;
                        end
                    end
                end
                ACCESS: begin
                    state    <= WAIT;
                    wait_cnt <= 3'(RD_LAT);
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 3'd1;
                    // writes also sit out the full read latency so every access has the same timing
                    if (wait_cnt == 3'd1) begin
                        state <= RESP;
                        if (!owner) begin
                            if_rdata <= ram_q;
                            if_ack   <= 1'b1;
                        end else begin
                            d_ack <= 1'b1;
                            if (!lat_we)
                                d_rdata <= ram_q;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ram_addr = lat_addr;
    assign ram_data = lat_wdata;
    assign ram_wren = (state == ACCESS) && lat_we && owner;
    assign busy     = (state != IDLE);
    assign if_stall = if_req && !if_ack;
    assign d_stall  = d_req && !d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: behavioural RAM plus per-requester expected-data queues.
module tb_mem_port_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_ack, if_stall;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we, d_ack, d_stall;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data, ram_q;
    logic          ram_wren, busy, owner;

    logic [DW-1:0] mem [0:255];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int t0;
    int wren_cnt = 0;
    int if_acks = 0;
    int d_acks = 0;
    int if_ack_cyc = 0;
    int d_ack_cyc = 0;
    int d_acks_start;
    int ack_order[$];
    int ack_cyc[$];
    bit if_hold = 1'b0;
    bit d_hold = 1'b0;
    logic [DW-1:0] if_q[$];
    logic [DW-1:0] d_q[$];
    logic [DW-1:0] if_hold_exp, d_hold_exp;
    logic [DW-1:0] d_last = '0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    // Single-port RAM with one cycle of read latency, read-before-write.
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr[7:0]] <= ram_data;
        ram_q <= mem[ram_addr[7:0]];
    end

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (ram_wren) wren_cnt++;
        check("if_stall", if_stall, if_req && !if_ack);
        check("d_stall", d_stall, d_req && !d_ack);
        if (if_ack) begin
            if_acks++;
            if_ack_cyc = cyc;
            ack_order.push_back(0);
            ack_cyc.push_back(cyc);
            check("if_owner", owner, 1'b0);
            check("if_q_nonempty", if_q.size() != 0, 1'b1);
            if (if_q.size() != 0) check("if_rdata", if_rdata, if_q.pop_front());
            if (if_hold) if_q.push_back(if_hold_exp);
            else if_req = 1'b0;
        end
        if (d_ack) begin
            d_acks++;
            d_ack_cyc = cyc;
            ack_order.push_back(1);
            ack_cyc.push_back(cyc);
            check("d_owner", owner, 1'b1);
            check("d_q_nonempty", d_q.size() != 0, 1'b1);
            if (d_q.size() != 0) check("d_rdata", d_rdata, d_q.pop_front());
            if (d_hold) d_q.push_back(d_hold_exp);
            else d_req = 1'b0;
        end
    endtask

    task automatic issue_if(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        if_req  = 1'b1;
        if_addr = a;
        if_q.push_back(exp);
        if_hold_exp = exp;
    endtask

    task automatic issue_d(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input logic [DW-1:0] exp_rd);
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        if (!we) d_last = exp_rd;
        d_q.push_back(d_last);
        d_hold_exp = d_last;
    endtask

    task automatic run_until(input int n_if, input int n_d);
        int budget = 200;
        while ((if_acks < n_if || d_acks < n_d) && budget > 0) begin
            step();
            budget--;
        end
        check("ack_timeout", (if_acks >= n_if) && (d_acks >= n_d), 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if_req = 1'b0;
        d_req = 1'b0;
        if_hold = 1'b0;
        d_hold = 1'b0;
        #1;
        check("reset_outputs", {if_ack, if_rdata, if_stall, d_ack, d_rdata, d_stall,
                                ram_addr, ram_data, ram_wren, busy, owner}, '0);
        if_q.delete();
        d_q.delete();
        d_last = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", {if_ack, d_ack, busy, ram_wren}, '0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 7 + 3);
        mem[8'h10] = 16'h8123;
        mem[8'h20] = 16'h1234;
        mem[8'h50] = 16'h5555;
        do_reset();

        // Single fetch; address change after the grant must be ignored.
        wren_cnt = 0;
        t0 = cyc;
        issue_if(16'h0010, 16'h8123);
        step();
        if_addr = 16'h0050;
        run_until(if_acks + 1, d_acks);
        check("t1_if_latency", if_ack_cyc - t0, 3);
        check("t1_no_wren", wren_cnt, 0);
        check("t1_ram_addr_hold", ram_addr, 16'h0010);
        step();
        check("t1_idle", busy, 1'b0);

        // Data write then read of the same address.
        wren_cnt = 0;
        issue_d(1'b1, 16'h0040, 16'hBEEF, '0);
        run_until(if_acks, d_acks + 1);
        step();
        check("t2_wren_once", wren_cnt, 1);
        issue_d(1'b0, 16'h0040, 16'h0000, 16'hBEEF);
        run_until(if_acks, d_acks + 1);
        step();
        check("t2_wren_total", wren_cnt, 1);
        check("t2_if_rdata_kept", if_rdata, 16'h8123);

        // Simultaneous requests from a clean state: data first, fetch one access later.
        do_reset();
        ack_order.delete();
        t0 = cyc;
        issue_d(1'b0, 16'h0040, 16'h0000, 16'hBEEF);
        issue_if(16'h0020, 16'h1234);
        run_until(if_acks + 1, d_acks + 1);
        check("t3_d_cycle", d_ack_cyc - t0, 3);
        check("t3_if_cycle", if_ack_cyc - t0, 7);
        check("t3_order0", ack_order[0], 1);
        check("t3_order1", ack_order[1], 0);
        step();

`ifndef ARB_ROUND_ROBIN_EN
        // Data held back-to-back; fetch forced through after four lost arbitrations.
        t0 = cyc;
        d_acks_start = d_acks;
        d_hold = 1'b1;
        issue_d(1'b0, 16'h0040, 16'h0000, 16'hBEEF);
        issue_if(16'h0010, 16'h8123);
        run_until(if_acks + 1, d_acks);
        check("t4_if_cycle", if_ack_cyc - t0, 19);
        check("t4_d_before_if", d_acks - d_acks_start, 4);
        check("t4_starve_clr", dut.starve_cnt, 4'd0);
        d_hold = 1'b0;
        run_until(if_acks, d_acks + 1);
        check("t4_d_after_if", d_ack_cyc - t0, 23);
        step();
`else
        // Both held continuously: grants alternate with uniform spacing.
        ack_order.delete();
        ack_cyc.delete();
        if_hold = 1'b1;
        d_hold = 1'b1;
        issue_d(1'b0, 16'h0040, 16'h0000, 16'hBEEF);
        issue_if(16'h0010, 16'h8123);
        run_until(if_acks + 2, d_acks + 2);
        for (int i = 0; i < 4; i++) check("rr_order", ack_order[i], (i % 2 == 0) ? 1 : 0);
        for (int i = 1; i < 4; i++) check("rr_spacing", ack_cyc[i] - ack_cyc[i-1], 4);
        if_hold = 1'b0;
        d_hold = 1'b0;
        run_until(if_acks + 1, d_acks + 1);
        step();
`endif

        // Reset during WAIT discards the fetch; a re-issued fetch then completes.
        issue_if(16'h0010, 16'h8123);
        step();
        step();
        check("t5_busy_in_wait", busy, 1'b1);
        do_reset();
        t0 = cyc;
        issue_if(16'h0020, 16'h1234);
        run_until(if_acks + 1, d_acks);
        check("t5_if_latency", if_ack_cyc - t0, 3);
        step();
        check("t5_if_q_empty", if_q.size(), 0);
        check("t5_d_q_empty", d_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between the instruction-fetch requester (IF, read-only) and the data-memory requester (MEM stage, read/write).
- Sits between the pipeline's fetch/MEM logic and the RAM, replacing the separate instruction and data RAM instances with one arbitrated port.
- Issues one access at a time through a small FSM.
- Provides stall signals to the pipeline and a starvation guard so fetch always makes progress.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- RD_LAT, 1, RAM read latency in cycles from the sampling edge to valid ram_q. Legal range 1..4.
- MAX_WAIT, 4, number of cycles IF may lose arbitration before it gets forced priority. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  AW  fetch address
- if_ack  out  1  one-cycle pulse: fetch complete, if_rdata valid
- if_rdata  out  DW  fetched instruction; holds until the next IF ack
- if_stall  out  1  if_req && !if_ack (combinational)
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_ack  out  1  one-cycle pulse: data access complete
- d_rdata  out  DW  read data; holds until the next data-read ack
- d_stall  out  1  d_req && !d_ack (combinational)
- ram_addr  out  AW  RAM address
- ram_data  out  DW  RAM write data
- ram_wren  out  1  RAM write enable
- ram_q  in  DW  RAM read data
- busy  out  1  FSM not in IDLE
- owner  out  1  current or last grant: 0 = IF, 1 = data

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; starvation counter 0; wait counter 0.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - Arbitration happens only in IDLE.
  - If any request is pending, latch the winner's addr/we/wdata, set owner, go to ACCESS.
  - Requests not pending: stay in IDLE.
- Arbitration rule: data wins over IF. Exception: if IF wins when both are requesting and starve_cnt >= MAX_WAIT.
- starve_cnt: 4-bit, saturating.
  - Increments on each IDLE cycle where if_req=1 and IF is not granted.
  - Clears when IF is granted.
- ACCESS (exactly 1 cycle):
  - ram_addr and ram_data are driven from the latched values.
  - ram_wren = latched we && owner==1. ram_wren is high only in this state.
  - Go to WAIT with wait_cnt = RD_LAT.
- WAIT: decrement wait_cnt each cycle. On the last WAIT cycle:
  - Capture ram_q into if_rdata (owner=0) or d_rdata (owner=1, read).
  - Assert the matching ack at that edge.
  - Data writes still take the full WAIT time, so latency is uniform. d_rdata is unchanged on a write.
- RESP (1 cycle): ack is high; go to IDLE.
- Latency: req high in cycle 0 in IDLE, ACCESS in cycle 1, ack in cycle 2+RD_LAT. Minimum period is 3+RD_LAT cycles per access.
- Requester rule: clear req at the same edge that samples ack. A req still high in the IDLE cycle after RESP counts as a new request.
- Address/data changes after the grant are ignored. If req drops before ack, the access still completes and ack still pulses.
- ram_addr and ram_data hold their last value outside ACCESS; ram_wren=0 outside ACCESS.
- A write and a fetch never overlap. Read-after-write to the same address through this block returns the new data.
- Reset mid-operation: immediate return to IDLE. The pending access is discarded, no ack is issued, and ram_wren drops asynchronously.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: the starvation counter is removed. On simultaneous requests the requester not granted last wins (owner toggles); a single requester always wins.
- Undefined: data-priority with MAX_WAIT starvation guard, as above.

Test Plan:
- Single fetch: RAM[0x0010]=0x8123, if_req with if_addr=0x0010 in cycle 0 -> ram_wren=0, if_ack in cycle 3 (RD_LAT=1), if_rdata=0x8123, if_stall high in cycles 0..2.
- Data write then read: write 0xBEEF to 0x0040 (d_we=1), then read 0x0040 -> ram_wren high exactly 1 cycle; second d_ack gives d_rdata=0xBEEF; if_rdata unchanged.
- Simultaneous requests, starve_cnt=0: data wins first; IF is acked one access later (cycle 7). owner sequence 1 then 0.
- Starvation: d_req held continuously with back-to-back accesses, if_req held -> IF is granted once starve_cnt reaches 4 (after 4 losing IDLE cycles); starve_cnt is 0 after the grant.
- Reset in WAIT: assert rst during an IF read -> all outputs 0 immediately, no if_ack. After release, a re-issued request completes normally.
- With ARB_ROUND_ROBIN_EN and both requests held continuously -> grants alternate D, IF, D, IF; each ack is 4 cycles apart.
